// File: rtl/tpu_pkg.sv
// Shared width defaults and saturating-add helpers for the TPU MAC row.
package tpu_pkg;
  localparam int TPU_COLS    = 4;
  localparam int TPU_BITS_AB = 8;
  localparam int TPU_BITS_C  = 16;

  // Sum of two sign-extended operands clipped to a w-bit signed range (w <= 63).
  function automatic logic [63:0] sat_add(input logic signed [63:0] a,
                                          input logic signed [63:0] b,
                                          input int w);
    logic signed [64:0] s, mx, mn;
    s  = {a[63], a} + {b[63], b};
    mx = (65'sd1 <<< (w - 1)) - 65'sd1;
    mn = -mx - 65'sd1;
    if (s > mx)      sat_add = mx[63:0];
    else if (s < mn) sat_add = mn[63:0];
    else             sat_add = s[63:0];
  endfunction

  function automatic logic sat_hit(input logic signed [63:0] a,
                                   input logic signed [63:0] b,
                                   input int w);
    sat_hit = (sat_add(a, b, w) != 64'(a + b));
  endfunction
endpackage

// File: rtl/tpu_mac_row_if.sv
// Control/data bundle of the TPU MAC row; master drives operands, slave is the row.
interface tpu_mac_row_if
  import tpu_pkg::*;
#(
  parameter int COLS    = TPU_COLS,
  parameter int BITS_AB = TPU_BITS_AB,
  parameter int BITS_C  = TPU_BITS_C
);
  logic                    en;
  logic                    clr;
  logic                    wr_en;
  logic                    valid_in;
  logic [BITS_AB-1:0]      a_in;
  logic [COLS*BITS_AB-1:0] b_in;
  logic [COLS*BITS_C-1:0]  c_in;
  logic [BITS_AB-1:0]      a_out;
  logic                    valid_out;
  logic [COLS*BITS_C-1:0]  c_out;
  logic [COLS-1:0]         ovf;
  logic [15:0]             beat_cnt;

  modport master (output en, clr, wr_en, valid_in, a_in, b_in, c_in,
                  input  a_out, valid_out, c_out, ovf, beat_cnt);
  modport slave  (input  en, clr, wr_en, valid_in, a_in, b_in, c_in,
                  output a_out, valid_out, c_out, ovf, beat_cnt);
endinterface

// File: rtl/tpu_mac_pe.sv
// One MAC processing element: registered A/valid stage plus accumulator.
// TPU_MAC_SAT_EN selects saturating accumulation with a sticky ovf flag.
module tpu_mac_pe
  import tpu_pkg::*;
#(
  parameter int BITS_AB = TPU_BITS_AB,
  parameter int BITS_C  = TPU_BITS_C
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic                      wr_en,
  input  logic                      valid_in,
  input  logic signed [BITS_AB-1:0] a_in,
  input  logic signed [BITS_AB-1:0] b,
  input  logic signed [BITS_C-1:0]  c_in,
  output logic signed [BITS_AB-1:0] a_out,
  output logic                      valid_out,
  output logic signed [BITS_C-1:0]  acc,
  output logic                      ovf
);
  logic signed [2*BITS_AB-1:0] prod;
  logic signed [BITS_C-1:0]    prod_x;
  logic signed [BITS_C-1:0]    sum;
  logic                        clip;

  assign prod   = a_in * b;
  assign prod_x = BITS_C'(prod);

`ifdef TPU_MAC_SAT_EN
  assign sum  = BITS_C'(sat_add(64'(acc), 64'(prod_x), BITS_C));
  assign clip = sat_hit(64'(acc), 64'(prod_x), BITS_C);
`else
  assign sum  = acc + prod_x;
  assign clip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_out     <= '0;
      valid_out <= 1'b0;
    end else if (en) begin
      a_out     <= a_in;
      valid_out <= valid_in;
    end

  // clr beats wr_en beats accumulation; the A/valid stage above ignores both.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (wr_en) begin
      acc <= c_in;
    end else if (en && valid_in) begin
      acc <= sum;
      ovf <= ovf | clip;
    end
endmodule

// File: rtl/tpu_mac_row.sv
// Systolic row of COLS MAC PEs sharing A, with per-PE B/preload and a beat counter.
// Optional macro TPU_MAC_SAT_EN enables saturating accumulation in every PE.
module tpu_mac_row
  import tpu_pkg::*;
#(
  parameter int COLS    = TPU_COLS,
  parameter int BITS_AB = TPU_BITS_AB,
  parameter int BITS_C  = TPU_BITS_C
) (
  input  logic          clk,
  input  logic          rst_n,
  tpu_mac_row_if.slave  bus
);
  if (BITS_C < 2*BITS_AB) begin : g_chk_c
    $error("tpu_mac_row: BITS_C must be >= 2*BITS_AB");
  end
  if (BITS_C > 63) begin : g_chk_cmax
    $error("tpu_mac_row: BITS_C must be <= 63");
  end
  if (COLS < 1 || COLS > 16) begin : g_chk_cols
    $error("tpu_mac_row: COLS must be in 1..16");
  end

  logic [COLS:0][BITS_AB-1:0] a_chain;
  logic [COLS:0]              v_chain;
  logic [15:0]                cnt;
  logic                       last_hit;

  assign a_chain[0] = bus.a_in;
  assign v_chain[0] = bus.valid_in;

  for (genvar k = 0; k < COLS; k++) begin : g_pe
    tpu_mac_pe #(.BITS_AB(BITS_AB), .BITS_C(BITS_C)) u_pe (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (bus.en),
      .clr       (bus.clr),
      .wr_en     (bus.wr_en),
      .valid_in  (v_chain[k]),
      .a_in      (a_chain[k]),
      .b         (bus.b_in[k*BITS_AB +: BITS_AB]),
      .c_in      (bus.c_in[k*BITS_C +: BITS_C]),
      .a_out     (a_chain[k+1]),
      .valid_out (v_chain[k+1]),
      .acc       (bus.c_out[k*BITS_C +: BITS_C]),
      .ovf       (bus.ovf[k])
    );
  end

  assign bus.a_out     = a_chain[COLS];
  assign bus.valid_out = v_chain[COLS];

  // Counts exactly the beats the last PE folds into its accumulator.
  assign last_hit = bus.en && v_chain[COLS-1] && !bus.clr && !bus.wr_en;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)        cnt <= '0;
    else if (bus.clr)  cnt <= '0;
    else if (last_hit) cnt <= cnt + 16'd1;

  assign bus.beat_cnt = cnt;
endmodule

// File: tb/tb_tpu_mac_row.sv
// Randomized bench for tpu_mac_row against a beat-history reference model.
module tb_tpu_mac_row;
  localparam int COLS = 4;
  localparam int AB   = 8;
  localparam int CW   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tpu_mac_row_if #(.COLS(COLS), .BITS_AB(AB), .BITS_C(CW)) bus ();
  tpu_mac_row #(.COLS(COLS), .BITS_AB(AB), .BITS_C(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: beat history (newest first), accumulators in plain integers.
  typedef struct { logic signed [AB-1:0] a; bit v; } beat_t;
  beat_t  hist[$];
  longint macc[COLS];
  bit     movf[COLS];
  int     mcnt;

  task automatic model_reset();
    beat_t z;
    z.a = '0; z.v = 1'b0;
    hist.delete();
    for (int k = 0; k < COLS; k++) begin
      hist.push_back(z);
      macc[k] = 0;
      movf[k] = 1'b0;
    end
    mcnt = 0;
  endtask

  function automatic longint fold(input longint s, output bit hit);
    longint lim, t;
    lim = longint'(1) << (CW - 1);
    hit = 1'b0;
`ifdef TPU_MAC_SAT_EN
    if (s > lim - 1) begin s = lim - 1; hit = 1'b1; end
    if (s < -lim)    begin s = -lim;    hit = 1'b1; end
    return s;
`else
    t = s & ((lim << 1) - 1);
    if (t >= lim) t -= (lim << 1);
    return t;
`endif
  endfunction

  task automatic model_edge();
    beat_t  nb;
    longint bk;
    bit     hit;
    if (bus.en) begin
      nb.a = bus.a_in; nb.v = bus.valid_in;
      hist.push_front(nb);
      void'(hist.pop_back());
    end
    for (int k = 0; k < COLS; k++) begin
      bk = longint'($signed(bus.b_in[k*AB +: AB]));
      if (bus.clr) begin
        macc[k] = 0; movf[k] = 1'b0;
      end else if (bus.wr_en) begin
        macc[k] = longint'($signed(bus.c_in[k*CW +: CW]));
      end else if (bus.en && hist[k].v) begin
        macc[k] = fold(macc[k] + longint'(hist[k].a) * bk, hit);
        movf[k] = movf[k] | hit;
      end
    end
    if (bus.clr) mcnt = 0;
    else if (!bus.wr_en && bus.en && hist[COLS-1].v) mcnt = (mcnt + 1) % 65536;
  endtask

  task automatic check_all();
    for (int k = 0; k < COLS; k++) begin
      chk($sformatf("c_out[%0d]", k), $signed(bus.c_out[k*CW +: CW]), macc[k]);
      chk($sformatf("ovf[%0d]", k), bus.ovf[k], movf[k]);
    end
    chk("a_out", $signed(bus.a_out), hist[COLS-1].a);
    chk("valid_out", bus.valid_out, hist[COLS-1].v);
    chk("beat_cnt", bus.beat_cnt, mcnt);
  endtask

  task automatic drive(input bit e, input bit c, input bit w, input bit v,
                       input logic [AB-1:0] a, input logic [COLS*AB-1:0] b,
                       input logic [COLS*CW-1:0] cv);
    bus.en = e; bus.clr = c; bus.wr_en = w; bus.valid_in = v;
    bus.a_in = a; bus.b_in = b; bus.c_in = cv;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  logic [COLS*AB-1:0] bp;
  logic [COLS*CW-1:0] cp;
  longint bv[COLS];
  longint av[5];
  longint asum;

  initial begin
    bus.en = 0; bus.clr = 0; bus.wr_en = 0; bus.valid_in = 0;
    bus.a_in = '0; bus.b_in = '0; bus.c_in = '0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Single beat walks the row
    bp = {8'd4, 8'd3, 8'd2, 8'd1};
    drive(1, 0, 0, 1, 8'd3, bp, '0);
    repeat (3) drive(1, 0, 0, 0, 8'd0, bp, '0);
    for (int k = 0; k < COLS; k++)
      chk("single_beat_c", $signed(bus.c_out[k*CW +: CW]), 3 * (k + 1));
    chk("single_beat_aout", $signed(bus.a_out), 3);
    chk("single_beat_vout", bus.valid_out, 1);
    chk("single_beat_cnt", bus.beat_cnt, 1);

    // Overflow corner: two (-128)*(-128) products on PE0
    drive(1, 1, 0, 0, 8'd0, '0, '0);
    bp = {8'd0, 8'd0, 8'd0, 8'h80};
    repeat (2) drive(1, 0, 0, 1, 8'h80, bp, '0);
`ifdef TPU_MAC_SAT_EN
    chk("ovf_corner_c0", $signed(bus.c_out[CW-1:0]), 32767);
    chk("ovf_corner_ovf0", bus.ovf[0], 1);
`else
    chk("ovf_corner_c0", $signed(bus.c_out[CW-1:0]), -32768);
    chk("ovf_corner_ovf0", bus.ovf[0], 0);
`endif
    repeat (COLS) drive(1, 0, 0, 0, 8'd0, '0, '0);

    // Preload then accumulate
    cp = '0; cp[CW-1:0] = 16'd100;
    drive(1, 0, 1, 0, 8'd0, '0, cp);
    bp = {8'd0, 8'd0, 8'd0, 8'd5};
    drive(1, 0, 0, 1, 8'd2, bp, '0);
    chk("preload_c0", $signed(bus.c_out[CW-1:0]), 110);
    repeat (COLS) drive(1, 0, 0, 0, 8'd0, '0, '0);

    // clr drops the beat at PE0 but it still travels to valid_out
    bp = {8'd1, 8'd1, 8'd1, 8'd1};
    drive(1, 1, 0, 1, 8'd7, bp, '0);
    chk("clr_beat_c0", $signed(bus.c_out[CW-1:0]), 0);
    repeat (COLS-1) drive(1, 0, 0, 0, 8'd0, bp, '0);
    chk("clr_beat_vout", bus.valid_out, 1);
    chk("clr_beat_c0_late", $signed(bus.c_out[CW-1:0]), 0);

    // Stall of 3 cycles must give the same sums as an unstalled run
    drive(1, 1, 0, 0, 8'd0, '0, '0);
    for (int k = 0; k < COLS; k++) begin
      bv[k] = longint'($urandom_range(0, 40)) - 20;
      bp[k*AB +: AB] = AB'(bv[k]);
    end
    asum = 0;
    for (int i = 0; i < 5; i++) begin
      av[i] = longint'($urandom_range(0, 40)) - 20;
      asum += av[i];
      if (i == 2) repeat (3) drive(0, 0, 0, 1, AB'($urandom), bp, '0);
      drive(1, 0, 0, 1, AB'(av[i]), bp, '0);
    end
    repeat (COLS) drive(1, 0, 0, 0, 8'd0, bp, '0);
    for (int k = 0; k < COLS; k++)
      chk("stall_sum", $signed(bus.c_out[k*CW +: CW]), bv[k] * asum);

    // Random traffic with a mid-stream reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst_n = 1'b0;
        #1;
        chk("rst_c_out", bus.c_out, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_a_out", bus.a_out, 0);
        chk("rst_vout", bus.valid_out, 0);
        chk("rst_cnt", bus.beat_cnt, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (COLS + 1) begin
          drive(1, 0, 0, 0, AB'($urandom), '0, '0);
          chk("rst_no_vout", bus.valid_out, 0);
        end
      end
      cp = {$urandom, $urandom};
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 39) == 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6,
            AB'($urandom), $urandom, cp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
